imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 12 +
 rtl/imem_loader_if.sv | 32 +++
 rtl/imem_ldr_cksum.sv | 17 +
 rtl/imem_loader.sv | 111 +++++++++++
 tb/tb_imem_loader.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader: default widths and the
// controller state encoding.
package imem_loader_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_VERIFY = 3'd2;
  localparam logic [2:0] ST_CHECK  = 3'd3;
  localparam logic [2:0] ST_RUN    = 3'd4;
endpackage

// File: rtl/imem_loader_if.sv
// Host control/stream and instruction-memory port bundle for imem_loader.
interface imem_loader_if #(
  parameter int ADDR_W = imem_loader_pkg::ADDR_W_DEF,
  parameter int DATA_W = imem_loader_pkg::DATA_W_DEF
);
  logic              i_start;
  logic              i_abort;
  logic [ADDR_W-1:0] i_base;
  logic [ADDR_W:0]   i_len;
  logic              i_wvalid;
  logic [DATA_W-1:0] i_wdata;
  logic              o_wready;
  logic [ADDR_W-1:0] o_exa;
  logic [DATA_W-1:0] o_exwd;
  logic              o_exwe;
  logic              o_exre;
  logic [DATA_W-1:0] i_exrd;
  logic              o_busy;
  logic              o_done;
  logic              o_err;
  logic              o_cpu_rst_n;

  modport slave (
    input  i_start, i_abort, i_base, i_len, i_wvalid, i_wdata, i_exrd,
    output o_wready, o_exa, o_exwd, o_exwe, o_exre, o_busy, o_done, o_err, o_cpu_rst_n
  );

  modport master (
    output i_start, i_abort, i_base, i_len, i_wvalid, i_wdata, i_exrd,
    input  o_wready, o_exa, o_exwd, o_exwe, o_exre, o_busy, o_done, o_err, o_cpu_rst_n
  );
endinterface

// File: rtl/imem_ldr_cksum.sv
// Modular (2^DATA_W) additive checksum accumulator; clear has priority over enable.
module imem_ldr_cksum #(
  parameter int DATA_W = imem_loader_pkg::DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] sum
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   sum <= '0;
    else if (clr) sum <= '0;
    else if (en)  sum <= sum + d;
  end
endmodule

// File: rtl/imem_loader.sv
// Streams host words into instruction memory, optionally re-reads them to
// compare checksums, then releases the CPU from reset.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int VERIFY = 1
) (
  input logic         clk,
  input logic         rst_n,
  imem_loader_if.slave bus
);
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [2:0]        state;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W:0]   len, cnt, len_sat;
  logic              err_q, done_q;
  logic [DATA_W-1:0] wsum, rsum;
  logic              busy, start_ok, abort_ok, accept, last, sums_eq;
  logic [ADDR_W-1:0] exa_w;

  assign busy     = (state == ST_LOAD) | (state == ST_VERIFY) | (state == ST_CHECK);
  assign start_ok = bus.i_start & ~bus.i_abort & ((state == ST_IDLE) | (state == ST_RUN));
  assign abort_ok = bus.i_abort & busy;
  assign len_sat  = (bus.i_len > DEPTH) ? DEPTH : bus.i_len;
  assign accept   = (state == ST_LOAD) & bus.i_wvalid;
  assign last     = (cnt == len - 1'b1);
  assign sums_eq  = (wsum == rsum);
  assign exa_w    = base + cnt[ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      base   <= '0;
      len    <= '0;
      cnt    <= '0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort_ok) begin
        state <= ST_IDLE;
      end else if (start_ok) begin
        base  <= bus.i_base;
        len   <= len_sat;
        cnt   <= '0;
        err_q <= 1'b0;
        if (len_sat == '0) begin
          state  <= ST_RUN;
          done_q <= 1'b1;
        end else begin
          state <= ST_LOAD;
        end
      end else begin
        case (state)
          ST_LOAD: if (accept) begin
            if (last) begin
              cnt <= '0;
              if (VERIFY != 0) state <= ST_VERIFY;
              else begin
                state  <= ST_RUN;
                done_q <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_VERIFY: begin
            if (last) begin
              cnt   <= '0;
              state <= ST_CHECK;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_CHECK: begin
            if (sums_eq) state <= ST_RUN;
            else begin
              state <= ST_IDLE;
              err_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  imem_ldr_cksum #(.DATA_W(DATA_W)) u_wsum (
    .clk(clk), .rst_n(rst_n), .clr(start_ok), .en(accept),
    .d(bus.i_wdata), .sum(wsum)
  );

  imem_ldr_cksum #(.DATA_W(DATA_W)) u_rsum (
    .clk(clk), .rst_n(rst_n), .clr(start_ok), .en(state == ST_VERIFY),
    .d(bus.i_exrd), .sum(rsum)
  );

  // All memory-side outputs are gated by state so a reset silences them at once.
  assign bus.o_wready    = (state == ST_LOAD);
  assign bus.o_exwe      = accept;
  assign bus.o_exwd      = accept ? bus.i_wdata : '0;
  assign bus.o_exre      = (state == ST_VERIFY);
  assign bus.o_exa       = ((state == ST_LOAD) | (state == ST_VERIFY)) ? exa_w : '0;
  assign bus.o_busy      = busy;
  assign bus.o_done      = done_q | ((state == ST_CHECK) & sums_eq & ~bus.i_abort);
  assign bus.o_err       = err_q;
  assign bus.o_cpu_rst_n = (state == ST_RUN);
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: vector table, hand-written corner
// sequences and randomized loads against a transaction-level model.
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(8), .DATA_W(16)) bus ();
  imem_loader #(.ADDR_W(8), .DATA_W(16), .VERIFY(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  // Memory model; poison forces one address to store 0 so verify must catch it.
  logic [15:0] mem [256];
  bit          poison_en = 1'b0;
  logic [7:0]  poison_a  = 8'h00;
  always @(posedge clk)
    if (bus.o_exwe) mem[bus.o_exa] <= (poison_en && bus.o_exa == poison_a) ? 16'h0 : bus.o_exwd;
  assign bus.i_exrd = mem[bus.o_exa];

  typedef struct { logic [7:0] a; logic [15:0] d; } wr_t;
  wr_t        wr_q[$];
  logic [7:0] rd_q[$];
  int         done_cnt = 0;
  int         viol = 0;

  always @(negedge clk) if (rst_n) begin
    if (bus.o_exwe) wr_q.push_back('{bus.o_exa, bus.o_exwd});
    if (bus.o_exre) rd_q.push_back(bus.o_exa);
    if (bus.o_done) done_cnt++;
    if (bus.o_exwe && bus.o_exre) viol++;
    if (bus.o_exwe && !bus.i_wvalid) viol++;
    if (!bus.o_busy && (bus.o_exwe || bus.o_exre || bus.o_wready || bus.o_exa != 0 || bus.o_exwd != 0)) viol++;
    if (bus.o_cpu_rst_n && bus.o_busy) viol++;
  end

  int checks = 0;
  int errors = 0;
  logic [15:0] words [256];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic int sat_len(input logic [8:0] l);
    return (l > 9'd256) ? 256 : int'(l);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Run one load; expected trace comes from words[] and base, outcome from caller.
  task automatic do_load(input string nm, input logic [7:0] b, input logic [8:0] l,
                         input int gap_pct, input bit pen, input logic [7:0] pa,
                         input int exp_done, input bit exp_err);
    int w0, r0, d0, n, k, cyc, bad;
    w0 = wr_q.size(); r0 = rd_q.size(); d0 = done_cnt;
    n = sat_len(l);
    tick();
    poison_en = pen; poison_a = pa;
    bus.i_start = 1'b1; bus.i_base = b; bus.i_len = l;
    tick();
    bus.i_start = 1'b0;
    k = 0; cyc = 0;
    while (cyc < 2000) begin
      bus.i_wvalid = (k < n) && ($urandom_range(0, 99) >= gap_pct);
      bus.i_wdata  = bus.i_wvalid ? words[k] : 16'($urandom);
      @(negedge clk);
      if (bus.i_wvalid && bus.o_wready) k++;
      if (!bus.o_busy) break;
      tick();
      cyc++;
    end
    bus.i_wvalid = 1'b0;
    chk({nm, " finished"}, 32'(cyc < 2000), 1);
    tick();
    chk({nm, " n_writes"}, 32'(wr_q.size() - w0), 32'(n));
    chk({nm, " n_reads"}, 32'(rd_q.size() - r0), 32'(n));
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (w0 + i < wr_q.size())
        if (wr_q[w0+i].a != 8'(b + i) || wr_q[w0+i].d != words[i]) bad++;
      if (r0 + i < rd_q.size())
        if (rd_q[r0+i] != 8'(b + i)) bad++;
    end
    chk({nm, " trace_bad"}, 32'(bad), 0);
    chk({nm, " done_pulses"}, 32'(done_cnt - d0), 32'(exp_done));
    chk({nm, " err"}, 32'(bus.o_err), 32'(exp_err));
    chk({nm, " cpu_rst_n"}, 32'(bus.o_cpu_rst_n), 32'(exp_done));
    chk({nm, " busy"}, 32'(bus.o_busy), 0);
  endtask

  typedef struct {
    string nm; logic [7:0] base; logic [8:0] len; bit pen; logic [7:0] pa;
    int exp_n; int exp_done; bit exp_err;
  } vec_t;
  vec_t tbl[6];

  initial begin
    bus.i_start = 0; bus.i_abort = 0; bus.i_base = 0; bus.i_len = 0;
    bus.i_wvalid = 0; bus.i_wdata = 0;
    #2;
    chk("rst busy", 32'(bus.o_busy), 0);
    chk("rst cpu_rst_n", 32'(bus.o_cpu_rst_n), 0);
    chk("rst strobes", {bus.o_exwe, bus.o_exre, bus.o_wready, bus.o_done, bus.o_err}, 0);
    chk("rst exa", 32'(bus.o_exa), 0);
    #20; tick(); rst_n = 1'b1;

    tbl[0] = '{"v_basic",   8'h10, 9'd4,     0, 8'h00, 4,   1, 0};
    tbl[1] = '{"v_wrap",    8'hFE, 9'd3,     0, 8'h00, 3,   1, 0};
    tbl[2] = '{"v_corrupt", 8'h10, 9'd4,     1, 8'h11, 4,   0, 1};
    tbl[3] = '{"v_zero",    8'h33, 9'd0,     0, 8'h00, 0,   1, 0};
    tbl[4] = '{"v_sat",     8'h80, 9'h1FF,   0, 8'h00, 256, 1, 0};
    tbl[5] = '{"v_one",     8'h07, 9'd1,     0, 8'h00, 1,   1, 0};
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 256; i++) words[i] = 16'((i + 1) * 16'h1111);
      chk({tbl[t].nm, " model_len"}, 32'(sat_len(tbl[t].len)), 32'(tbl[t].exp_n));
      do_load(tbl[t].nm, tbl[t].base, tbl[t].len, 0, tbl[t].pen, tbl[t].pa,
              tbl[t].exp_done, tbl[t].exp_err);
    end

    // err is set from v_corrupt's neighbour? No: set it again, then a new start must clear it.
    for (int i = 0; i < 4; i++) words[i] = 16'h00A0 + 16'(i);
    do_load("err_set", 8'h50, 9'd2, 0, 1, 8'h51, 0, 1);
    poison_en = 1'b0;
    bus.i_start = 1'b1; bus.i_base = 8'h60; bus.i_len = 9'd2;
    tick(); bus.i_start = 1'b0;
    @(negedge clk);
    chk("err cleared by start", 32'(bus.o_err), 0);
    chk("cpu held in load", 32'(bus.o_cpu_rst_n), 0);
    tick();
    bus.i_abort = 1'b1; tick(); bus.i_abort = 1'b0;

    // wvalid 1,0,0,1 then abort after two words
    begin
      logic [3:0] pat;
      int d0;
      pat = 4'b1001; d0 = done_cnt;
      bus.i_start = 1'b1; bus.i_base = 8'h40; bus.i_len = 9'd8;
      tick(); bus.i_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
        bus.i_wvalid = pat[i]; bus.i_wdata = 16'hBEE0 + 16'(i);
        @(negedge clk);
        chk("gap exwe", 32'(bus.o_exwe), 32'(pat[i]));
        tick();
      end
      bus.i_wvalid = 1'b0; bus.i_abort = 1'b1;
      @(negedge clk);
      chk("abort same cycle busy", 32'(bus.o_busy), 1);
      tick(); bus.i_abort = 1'b0;
      @(negedge clk);
      chk("abort busy", 32'(bus.o_busy), 0);
      chk("abort wready", 32'(bus.o_wready), 0);
      chk("abort cpu_rst_n", 32'(bus.o_cpu_rst_n), 0);
      tick();
      chk("abort no done", 32'(done_cnt - d0), 0);
    end

    // start with simultaneous abort stays idle
    bus.i_start = 1'b1; bus.i_abort = 1'b1; bus.i_len = 9'd3;
    tick(); bus.i_start = 1'b0; bus.i_abort = 1'b0;
    @(negedge clk);
    chk("start+abort busy", 32'(bus.o_busy), 0);
    chk("start+abort wready", 32'(bus.o_wready), 0);
    tick();

    // zero-length: done exactly the cycle after start
    bus.i_start = 1'b1; bus.i_len = 9'd0;
    tick(); bus.i_start = 1'b0;
    @(negedge clk);
    chk("zero done", 32'(bus.o_done), 1);
    chk("zero run", 32'(bus.o_cpu_rst_n), 1);
    tick();
    @(negedge clk);
    chk("zero done one cycle", 32'(bus.o_done), 0);
    tick();

    // reset dropped between edges while verifying
    begin
      int c;
      bus.i_start = 1'b1; bus.i_base = 8'h20; bus.i_len = 9'd4;
      tick(); bus.i_start = 1'b0;
      c = 0;
      bus.i_wvalid = 1'b1;
      while (c < 50) begin
        bus.i_wdata = 16'(c);
        @(negedge clk);
        if (bus.o_exre) break;
        tick(); c++;
      end
      bus.i_wvalid = 1'b0;
      chk("reached verify", 32'(c < 50), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async rst exre", 32'(bus.o_exre), 0);
      chk("async rst busy", 32'(bus.o_busy), 0);
      chk("async rst exa", 32'(bus.o_exa), 0);
      chk("async rst cpu", 32'(bus.o_cpu_rst_n), 0);
      tick(); tick(); rst_n = 1'b1; tick();
    end

    // randomized loads
    for (int r = 0; r < 25; r++) begin
      logic [7:0] b, pa;
      logic [8:0] l;
      logic [15:0] ws, rs;
      int n, pidx;
      bit pen;
      b = 8'($urandom);
      l = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(256, 511)) : 9'($urandom_range(0, 24));
      n = sat_len(l);
      for (int i = 0; i < n; i++) words[i] = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      pen = (n > 0) && ($urandom_range(0, 2) == 0);
      pidx = (n > 0) ? $urandom_range(0, n - 1) : 0;
      pa = 8'(b + pidx);
      ws = 0; rs = 0;
      for (int i = 0; i < n; i++) begin
        ws += words[i];
        rs += (pen && i == pidx) ? 16'h0 : words[i];
      end
      do_load($sformatf("rand%0d", r), b, l, 30, pen, pa,
              (ws == rs) ? 1 : 0, ws != rs);
    end

    chk("invariants", 32'(viol), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
